// File: rtl/lsu_pkg.sv
// Shared types for the LSU-to-TileLink host: bus opcodes, RV32I width codes, FSM states.
package lsu_pkg;
  localparam logic [2:0] TL_GET      = 3'b100;
  localparam logic [2:0] TL_PUT_FULL = 3'b000;
  localparam logic [2:0] TL_ACK      = 3'b000;
  localparam logic [2:0] TL_ACK_DATA = 3'b001;

  typedef enum logic [2:0] {
    F3_B  = 3'b000,
    F3_H  = 3'b001,
    F3_W  = 3'b010,
    F3_BU = 3'b100,
    F3_HU = 3'b101
  } funct3_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_GET,
    S_CAPT,
    S_PUT,
    S_DONE
  } state_e;
endpackage

// File: rtl/lsu_load_align.sv
// Combinational load extract: picks the addressed byte/half of a bus word and sign/zero extends.
module lsu_load_align
  import lsu_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [2:0]  funct3_i,
  output logic [31:0] data_o
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = word_i[7:0];
    case (lane_i)
      2'd1:    byte_sel = word_i[15:8];
      2'd2:    byte_sel = word_i[23:16];
      2'd3:    byte_sel = word_i[31:24];
      default: byte_sel = word_i[7:0];
    endcase
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];

    case (funct3_i)
      F3_B:    data_o = {{24{byte_sel[7]}}, byte_sel};
      F3_BU:   data_o = {24'd0, byte_sel};
      F3_H:    data_o = {{16{half_sel[15]}}, half_sel};
      F3_HU:   data_o = {16'd0, half_sel};
      default: data_o = word_i;
    endcase
  end
endmodule

// File: rtl/lsu_tl_host.sv
// LSU to TileLink-UL host: word GET/PUT_FULL, sub-word stores done as read-modify-write.
// Optional LSU_MISALIGN_TRAP_EN: trap misaligned half/word accesses instead of force-aligning.
module lsu_tl_host
  import lsu_pkg::*;
#(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              lsu_req_i,
  input  logic              lsu_we_i,
  input  logic [2:0]        lsu_funct3_i,
  input  logic [31:0]       lsu_addr_i,
  input  logic [DATA_W-1:0] lsu_wdata_i,
  output logic [DATA_W-1:0] lsu_rdata_o,
  output logic              lsu_done_o,
  output logic              lsu_stall_o,
  output logic              lsu_misalign_o,
  output logic              a_valid_o,
  output logic [ADDR_W-1:0] a_address_o,
  output logic [2:0]        a_opcode_o,
  output logic [DATA_W-1:0] a_data_o,
  output logic [1:0]        a_size_o,
  output logic [1:0]        a_mask_o,
  input  logic              d_valid_i,
  input  logic [2:0]        d_opcode_i,
  input  logic [1:0]        d_size_i,
  input  logic [DATA_W-1:0] d_data_i
);
  state_e            state_q, state_d;
  logic              we_q, we_d;
  logic [2:0]        f3_q, f3_d;
  logic [ADDR_W+1:0] addr_q, addr_d;
  logic [31:0]       data_q, data_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [31:0]       load_data;
  logic [31:0]       merged;
  logic [ADDR_W+1:0] req_addr;
  logic              req_mis;
  logic              unused_d;

  assign req_addr = lsu_addr_i[ADDR_W+1:0];
  assign req_mis  = (lsu_funct3_i[1:0] == 2'b01 && req_addr[0]) ||
                    (lsu_funct3_i[1:0] == 2'b10 && req_addr[1:0] != 2'b00);

  // Response type/size are implied by the request; only d_valid and data matter here.
  assign unused_d = ^{d_opcode_i, d_size_i, TL_ACK, TL_ACK_DATA, lsu_addr_i[31:ADDR_W+2]};

  lsu_load_align u_align (
    .word_i   (d_data_i),
    .lane_i   (addr_q[1:0]),
    .funct3_i (f3_q),
    .data_o   (load_data)
  );

  always_comb begin
    merged = d_data_i;
    case (f3_q[1:0])
      2'b00: merged[8*addr_q[1:0] +: 8] = data_q[7:0];
      2'b01: merged[16*addr_q[1]  +: 16] = data_q[15:0];
      default: merged = data_q;
    endcase
  end

`ifdef LSU_MISALIGN_TRAP_EN
  logic mis_q, mis_d;
`endif

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    f3_d        = f3_q;
    addr_d      = addr_q;
    data_d      = data_q;
    rdata_d     = rdata_q;
    a_valid_o   = 1'b0;
    a_opcode_o  = TL_GET;
    a_data_o    = '0;
    lsu_done_o  = 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
    mis_d       = mis_q;
`endif
    case (state_q)
      S_IDLE: if (lsu_req_i) begin
        we_d   = lsu_we_i;
        f3_d   = lsu_funct3_i;
        data_d = lsu_wdata_i;
`ifdef LSU_MISALIGN_TRAP_EN
        addr_d = req_addr;
        mis_d  = req_mis;
        if (req_mis)                                       state_d = S_DONE;
        else if (lsu_we_i && lsu_funct3_i[1:0] == 2'b10) state_d = S_PUT;
        else                                               state_d = S_GET;
`else
        addr_d = req_addr;
        if (req_mis) addr_d[1:0] = (lsu_funct3_i[1:0] == 2'b01) ? {req_addr[1], 1'b0} : 2'b00;
        if (lsu_we_i && lsu_funct3_i[1:0] == 2'b10) state_d = S_PUT;
        else                                        state_d = S_GET;
`endif
      end
      S_GET: begin
        a_valid_o  = 1'b1;
        a_opcode_o = TL_GET;
        if (d_valid_i) state_d = S_CAPT;
      end
      S_CAPT: begin
        if (we_q) begin
          data_d  = merged;
          state_d = S_PUT;
        end else begin
          rdata_d = load_data;
          state_d = S_DONE;
        end
      end
      S_PUT: begin
        a_valid_o  = 1'b1;
        a_opcode_o = TL_PUT_FULL;
        a_data_o   = data_q;
        if (d_valid_i) state_d = S_DONE;
      end
      S_DONE: begin
        lsu_done_o = 1'b1;
        state_d    = S_IDLE;
`ifdef LSU_MISALIGN_TRAP_EN
        mis_d      = 1'b0;
`endif
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      we_q    <= 1'b0;
      f3_q    <= 3'd0;
      addr_q  <= '0;
      data_q  <= '0;
      rdata_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      we_q    <= we_d;
      f3_q    <= f3_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
`ifdef LSU_MISALIGN_TRAP_EN
      mis_q   <= mis_d;
`endif
    end
  end

`ifdef LSU_MISALIGN_TRAP_EN
  assign lsu_misalign_o = mis_q && (state_q == S_DONE);
`else
  assign lsu_misalign_o = 1'b0;
`endif

  assign lsu_rdata_o = rdata_q;
  assign lsu_stall_o = lsu_req_i && !lsu_done_o;
  assign a_address_o = addr_q[ADDR_W+1:2];
  assign a_size_o    = 2'b10;
  assign a_mask_o    = 2'b10;
endmodule

// File: tb/tb_lsu_tl_host.sv
// Directed bench for lsu_tl_host with a word memory/adapter model and a per-cycle monitor.
module tb_lsu_tl_host;
  import lsu_pkg::*;
  localparam int ADDR_W = 12;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              lsu_req_i = 1'b0, lsu_we_i = 1'b0;
  logic [2:0]        lsu_funct3_i = 3'd0;
  logic [31:0]       lsu_addr_i = 32'd0, lsu_wdata_i = 32'd0;
  logic [31:0]       lsu_rdata_o;
  logic              lsu_done_o, lsu_stall_o, lsu_misalign_o;
  logic              a_valid_o;
  logic [ADDR_W-1:0] a_address_o;
  logic [2:0]        a_opcode_o;
  logic [31:0]       a_data_o;
  logic [1:0]        a_size_o, a_mask_o;
  logic              d_valid_i;
  logic [2:0]        d_opcode_i;
  logic [1:0]        d_size_i;
  logic [31:0]       d_data_i = 32'd0;

  always #5 clk = ~clk;

  lsu_tl_host #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .lsu_req_i(lsu_req_i), .lsu_we_i(lsu_we_i), .lsu_funct3_i(lsu_funct3_i),
    .lsu_addr_i(lsu_addr_i), .lsu_wdata_i(lsu_wdata_i), .lsu_rdata_o(lsu_rdata_o),
    .lsu_done_o(lsu_done_o), .lsu_stall_o(lsu_stall_o), .lsu_misalign_o(lsu_misalign_o),
    .a_valid_o(a_valid_o), .a_address_o(a_address_o), .a_opcode_o(a_opcode_o),
    .a_data_o(a_data_o), .a_size_o(a_size_o), .a_mask_o(a_mask_o),
    .d_valid_i(d_valid_i), .d_opcode_i(d_opcode_i), .d_size_i(d_size_i), .d_data_i(d_data_i)
  );

  // Adapter + memory: d_valid after wait_cfg stall cycles, read data returned on the next cycle.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  int   wait_cfg = 0, wcnt = 0, get_cnt = 0, put_cnt = 0, aval_cycles = 0;
  logic spur = 1'b0;
  assign d_valid_i  = (a_valid_o && wcnt >= wait_cfg) || spur;
  assign d_opcode_i = (a_opcode_o == TL_GET) ? TL_ACK_DATA : TL_ACK;
  assign d_size_i   = 2'b10;

  always @(posedge clk) begin
    if (a_valid_o) aval_cycles <= aval_cycles + 1;
    if (a_valid_o && d_valid_i) begin
      wcnt <= 0;
      if (a_opcode_o == TL_GET) begin
        d_data_i <= mem[a_address_o];
        get_cnt  <= get_cnt + 1;
      end else begin
        mem[a_address_o] <= a_data_o;
        put_cnt <= put_cnt + 1;
      end
    end else if (a_valid_o) wcnt <= wcnt + 1;
  end

  int checks = 0, errors = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] w, input logic [31:0] a,
                                         input logic [2:0] f3);
    logic [31:0] v;
    if (f3[1])      v = w;
    else if (f3[0]) v = w >> (16 * int'(a[1]));
    else            v = w >> (8 * int'(a[1:0]));
    case (f3)
      3'b000:  return v[7]  ? (v | 32'hFFFF_FF00) : (v & 32'h0000_00FF);
      3'b100:  return v & 32'h0000_00FF;
      3'b001:  return v[15] ? (v | 32'hFFFF_0000) : (v & 32'h0000_FFFF);
      3'b101:  return v & 32'h0000_FFFF;
      default: return v;
    endcase
  endfunction

  function automatic logic [31:0] m_store(input logic [31:0] old, input logic [31:0] a,
                                          input logic [2:0] f3, input logic [31:0] wd);
    logic [31:0] msk;
    int sh;
    if (f3[1:0] == 2'b00)      begin msk = 32'hFF;   sh = 8 * int'(a[1:0]); end
    else if (f3[1:0] == 2'b01) begin msk = 32'hFFFF; sh = 16 * int'(a[1]); end
    else                       begin msk = '1;       sh = 0; end
    return (old & ~(msk << sh)) | ((wd & msk) << sh);
  endfunction

  function automatic logic m_mis(input logic [31:0] a, input logic [2:0] f3);
`ifdef LSU_MISALIGN_TRAP_EN
    return (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
`else
    return 1'b0;
`endif
  endfunction

  // Monitor: protocol rules and model values on every out-of-reset cycle.
  logic [31:0] exp_rdata = 32'd0, exp_put = 32'd0;
  logic [11:0] exp_addr_w = 12'd0;
  logic        prev_hold = 1'b0;
  logic [31:0] prev_a;
  always @(negedge clk) begin
    if (rst_n) begin
      chk("stall", 32'(lsu_stall_o), 32'(lsu_req_i & ~lsu_done_o));
      if (lsu_done_o || !lsu_req_i) chk("rdata", lsu_rdata_o, exp_rdata);
      if (!(a_valid_o && a_opcode_o == TL_PUT_FULL)) chk("a_data_idle", a_data_o, 32'd0);
      if (a_valid_o) begin
        chk("a_size", 32'(a_size_o), 32'd2);
        chk("a_mask", 32'(a_mask_o), 32'd2);
        chk("a_addr", 32'(a_address_o), 32'(exp_addr_w));
        if (a_opcode_o == TL_PUT_FULL) chk("a_put_data", a_data_o, exp_put);
        else                           chk("a_opcode", 32'(a_opcode_o), 32'(TL_GET));
      end
      if (prev_hold) chk("a_stable", {a_data_o[15:0], 1'b0, a_opcode_o, a_address_o},
                         prev_a);
      prev_hold = a_valid_o && !d_valid_i;
      prev_a    = {a_data_o[15:0], 1'b0, a_opcode_o, a_address_o};
    end else prev_hold = 1'b0;
  end

  task automatic do_op(input string nm, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd, input int wt,
                       input int exp_lat, input int exp_gets, input int exp_puts);
    int g0, p0, cyc;
    logic [31:0] old;
    logic mis;
    mis = m_mis(addr, f3);
    wait_cfg = wt;
    @(posedge clk); #2;
    g0 = get_cnt; p0 = put_cnt;
    old = mem[addr[13:2]];
    exp_addr_w = addr[13:2];
    exp_put = m_store(old, addr, f3, wd);
    lsu_req_i = 1'b1; lsu_we_i = we; lsu_funct3_i = f3; lsu_addr_i = addr; lsu_wdata_i = wd;
    cyc = 0;
    while (cyc < 40) begin
      @(posedge clk); #1;
      cyc++;
      if (lsu_done_o) break;
    end
    chk({nm, "_latency"}, cyc, exp_lat);
    chk({nm, "_misalign"}, 32'(lsu_misalign_o), 32'(mis));
    if (!we && !mis) exp_rdata = m_load(old, addr, f3);
    lsu_req_i = 1'b0;
    @(posedge clk); #1;
    chk({nm, "_done_pulse"}, 32'(lsu_done_o | lsu_misalign_o), 32'd0);
    chk({nm, "_gets"}, get_cnt - g0, exp_gets);
    chk({nm, "_puts"}, put_cnt - p0, exp_puts);
    if (we) chk({nm, "_mem"}, mem[addr[13:2]], mis ? old : exp_put);
  endtask

  int a0, p0r;
  initial begin
    for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = 32'd0;
    mem[12'h080] = 32'h8899_AABB;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rdata", lsu_rdata_o, 32'd0);
    chk("rst_done", 32'(lsu_done_o), 32'd0);
    chk("rst_avalid", 32'(a_valid_o), 32'd0);
    chk("rst_misalign", 32'(lsu_misalign_o), 32'd0);
    rst_n = 1'b1;

    do_op("lb",  1'b0, 3'b000, 32'h201, 32'd0, 0, 3, 1, 0);
    chk("lb_lit", lsu_rdata_o, 32'hFFFF_FFAA);
    do_op("lhu", 1'b0, 3'b101, 32'h202, 32'd0, 0, 3, 1, 0);
    chk("lhu_lit", lsu_rdata_o, 32'h0000_8899);
    do_op("lbu", 1'b0, 3'b100, 32'h200, 32'd0, 0, 3, 1, 0);
    do_op("lh",  1'b0, 3'b001, 32'h200, 32'd0, 0, 3, 1, 0);
    chk("lh_lit", lsu_rdata_o, 32'hFFFF_AABB);
    do_op("lw_wrap", 1'b0, 3'b010, 32'hFFFF_4200, 32'd0, 1, 4, 1, 0);
    chk("lw_wrap_lit", lsu_rdata_o, 32'h8899_AABB);

    mem[12'h080] = 32'h1122_3344;
    do_op("sb",  1'b1, 3'b000, 32'h203, 32'h0000_005C, 0, 4, 1, 1);
    chk("sb_lit", mem[12'h080], 32'h5C22_3344);
    chk("sb_rdata_hold", lsu_rdata_o, 32'h8899_AABB);
    do_op("sh",  1'b1, 3'b001, 32'h202, 32'h1234_BEEF, 0, 4, 1, 1);
    chk("sh_lit", mem[12'h080], 32'hBEEF_3344);

    a0 = aval_cycles;
    do_op("sw_wait", 1'b1, 3'b010, 32'h010, 32'hDEAD_BEEF, 3, 5, 0, 1);
    chk("sw_wait_avalid_cycles", aval_cycles - a0, 4);
    chk("sw_lit", mem[12'h004], 32'hDEAD_BEEF);

`ifdef LSU_MISALIGN_TRAP_EN
    a0 = aval_cycles;
    do_op("lw_mis", 1'b0, 3'b010, 32'h102, 32'd0, 0, 1, 0, 0);
    do_op("sh_mis", 1'b1, 3'b001, 32'h203, 32'hAAAA, 0, 1, 0, 0);
    chk("mis_no_avalid", aval_cycles - a0, 0);
`else
    do_op("lh_force", 1'b0, 3'b001, 32'h201, 32'd0, 0, 3, 1, 0);
    chk("lh_force_lit", lsu_rdata_o, 32'h0000_3344);
    do_op("sw_force", 1'b1, 3'b010, 32'h013, 32'h0102_0304, 0, 2, 0, 1);
    chk("sw_force_lit", mem[12'h004], 32'h0102_0304);
`endif

    // Stray responses while idle must not start anything.
    a0 = aval_cycles; p0r = put_cnt;
    @(posedge clk); #2; spur = 1'b1;
    repeat (3) @(posedge clk);
    #2; spur = 1'b0;
    chk("spur_avalid", aval_cycles - a0, 0);
    chk("spur_done", 32'(lsu_done_o), 32'd0);

    // Reset while in CAPT of a halfword store abandons it.
    mem[12'h081] = 32'hCAFE_F00D;
    wait_cfg = 0;
    @(posedge clk); #2;
    a0 = get_cnt; p0r = put_cnt;
    exp_addr_w = 12'h081;
    exp_put = m_store(32'hCAFE_F00D, 32'h204, 3'b001, 32'h1234);
    lsu_req_i = 1'b1; lsu_we_i = 1'b1; lsu_funct3_i = 3'b001;
    lsu_addr_i = 32'h204; lsu_wdata_i = 32'h1234;
    @(posedge clk); @(posedge clk); #1;
    chk("rstcapt_gets", get_cnt - a0, 1);
    chk("rstcapt_avalid", 32'(a_valid_o), 32'd0);
    rst_n = 1'b0; lsu_req_i = 1'b0; exp_rdata = 32'd0;
    repeat (2) @(posedge clk);
    #2; rst_n = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("rstcapt_puts", put_cnt - p0r, 0);
    chk("rstcapt_mem", mem[12'h081], 32'hCAFE_F00D);
    chk("rstcapt_rdata", lsu_rdata_o, 32'd0);

    do_op("lw_after_rst", 1'b0, 3'b010, 32'h204, 32'd0, 0, 3, 1, 0);
    chk("lw_after_rst_lit", lsu_rdata_o, 32'hCAFE_F00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, got hang expected finish");
    $fatal(1);
  end
endmodule

// File: doc/lsu_tl_host.md
LSU_TL_HOST -- requirements
Module: lsu_tl_host

Interface
REQ-001 Parameters SHALL be: ADDR_W, 12, bus word-address width; DATA_W, 32, data width.
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  reset, synchronous, active-low.
REQ-004 lsu_req_i  in  1  core memory request; held high until lsu_done_o.
REQ-005 lsu_we_i  in  1  1 = store, 0 = load.
REQ-006 lsu_funct3_i  in  3  RV32I width/sign: LB/SB 000, LH/SH 001, LW/SW 010, LBU 100, LHU 101.
REQ-007 lsu_addr_i  in  32  byte address.
REQ-008 lsu_wdata_i  in  32  store data, right-aligned.
REQ-009 lsu_rdata_o  out  32  load result, aligned and extended.
REQ-010 lsu_done_o  out  1  one-cycle completion pulse.
REQ-011 lsu_stall_o  out  1  pipeline stall = lsu_req_i AND NOT lsu_done_o.
REQ-012 lsu_misalign_o  out  1  misaligned-access pulse (only when LSU_MISALIGN_TRAP_EN is defined).
REQ-013 a_valid_o, a_address_o[ADDR_W-1:0], a_opcode_o[2:0], a_data_o[31:0], a_size_o[1:0], a_mask_o[1:0]  out  A channel to the data-memory adapter.
REQ-014 d_valid_i, d_opcode_i[2:0], d_size_i[1:0], d_data_i[31:0]  in  D channel from the adapter.

Function
REQ-015 FSM states SHALL be IDLE, GET, CAPT, PUT, DONE.
REQ-016 IDLE SHALL latch lsu_we_i, lsu_funct3_i, lsu_addr_i and lsu_wdata_i at the edge where lsu_req_i=1.
REQ-017 Load or sub-word store: IDLE->GET. Word store: IDLE->PUT.
REQ-018 GET: a_valid_o=1, a_opcode_o=3'b100. PUT: a_valid_o=1, a_opcode_o=3'b000. In both states a_address_o=addr[ADDR_W+1:2], a_size_o=2'b10, a_mask_o=2'b10.
REQ-019 GET/PUT SHALL hold a_valid_o and all A fields stable until d_valid_i=1, then advance: GET->CAPT, PUT->DONE.
REQ-020 CAPT SHALL register d_data_i (fixed 1-cycle read latency). Load: CAPT->DONE. Sub-word store: merge, then CAPT->PUT.
REQ-021 Load extract: byte lane addr[1:0], half lane addr[1]. LB/LH sign-extend, LBU/LHU zero-extend. Result is registered into lsu_rdata_o when CAPT exits.
REQ-022 Sub-word store merge: replace only the addressed byte/half of the captured word with wdata[7:0] or wdata[15:0]. Other bytes SHALL be unchanged (read-modify-write).
REQ-023 DONE: lsu_done_o=1 for exactly one cycle, then DONE->IDLE. lsu_rdata_o holds its value until the next load's CAPT.
REQ-024 Latency from the request edge N (zero-wait bus): word store done at N+2, load at N+3, sub-word store at N+4.
REQ-025 d_valid_i outside GET/PUT SHALL be ignored. lsu_req_i outside IDLE SHALL be ignored. A back-to-back request is sampled in IDLE on the cycle after DONE.
REQ-026 a_valid_o SHALL be 0 in IDLE, CAPT and DONE. a_data_o=0 outside PUT.
REQ-027 Top address bits above ADDR_W+1 SHALL be ignored; wrap-around within the memory depth.

Reset
REQ-028 When rst_n=0 at posedge clk: state=IDLE; lsu_rdata_o, lsu_done_o, lsu_misalign_o, a_valid_o all 0.
REQ-029 Reset mid-operation SHALL abandon the transaction. No PUT is issued after reset deasserts.

Configuration
REQ-030 Macro LSU_MISALIGN_TRAP_EN.
- Defined: a halfword with addr[0]=1 or a word with addr[1:0]!=0 pulses lsu_misalign_o and lsu_done_o in the cycle after the request. No bus transaction is issued.
- Undefined: misaligned low bits are forced to the natural alignment (half: addr[0]=0; word: addr[1:0]=0), and lsu_misalign_o is tied 0.

Structure
REQ-031 Package lsu_pkg SHALL hold the TL opcode constants (GET 3'b100, PUT_FULL 3'b000, ACK 3'b000, ACK_DATA 3'b001), the funct3 enum and the FSM state enum.
REQ-032 Sub-module lsu_load_align SHALL be combinational byte/half extract and extend, instanced once.

Verification
REQ-033 Word memory 0x80 preloaded with 0x8899AABB; LB at byte addr 0x201 -> lsu_rdata_o=0xFFFFFFAA, done at N+3.
REQ-034 Same word; LHU at byte addr 0x202 -> lsu_rdata_o=0x00008899.
REQ-035 SB 0x5C at byte addr 0x203 onto 0x11223344 -> word becomes 0x5C223344; one GET then one PUT; done at N+4.
REQ-036 SW 0xDEADBEEF at byte addr 0x010 with d_valid_i held low 3 cycles -> a_valid_o held 4 cycles with stable fields; done 1 cycle after accept.
REQ-037 rst_n=0 during CAPT of an SH -> FSM returns to IDLE, no PUT, target word unchanged.
REQ-038 With LSU_MISALIGN_TRAP_EN defined: LW at byte addr 0x102 -> lsu_misalign_o=1 for one cycle, a_valid_o never asserted.
